// File: rtl/alu_rr_arbiter.sv
// +--------------------------------------------------------------------------+
// | alu_rr_arbiter: round-robin arbiter sharing one alu between N_REQ        |
// | requesters, with a registered single-slot valid/ready response channel.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package pkg_cpu_types;
  typedef logic [3:0] alu_fun_t;
  localparam alu_fun_t ALU_ADD  = 4'd0;
  localparam alu_fun_t ALU_SUB  = 4'd1;
  localparam alu_fun_t ALU_AND  = 4'd2;
  localparam alu_fun_t ALU_OR   = 4'd3;
  localparam alu_fun_t ALU_XOR  = 4'd4;
  localparam alu_fun_t ALU_SLT  = 4'd5;
  localparam alu_fun_t ALU_SLTU = 4'd6;
  localparam alu_fun_t ALU_SLL  = 4'd7;
  localparam alu_fun_t ALU_SRL  = 4'd8;
  localparam alu_fun_t ALU_SRA  = 4'd9;
endpackage

module alu
  import pkg_cpu_types::*;
(
  input  logic [31:0] i_in0,
  input  logic [31:0] i_in1,
  input  alu_fun_t    i_fun,
  output logic [31:0] o_alu_out,
  output logic        o_err_ufun_unk
);
  always_comb begin
    o_alu_out      = '0;
    o_err_ufun_unk = 1'b0;
    case (i_fun)
      ALU_ADD:  o_alu_out = i_in0 + i_in1;
      ALU_SUB:  o_alu_out = i_in0 - i_in1;
      ALU_AND:  o_alu_out = i_in0 & i_in1;
      ALU_OR:   o_alu_out = i_in0 | i_in1;
      ALU_XOR:  o_alu_out = i_in0 ^ i_in1;
      ALU_SLT:  o_alu_out = {31'd0, $signed(i_in0) < $signed(i_in1)};
      ALU_SLTU: o_alu_out = {31'd0, i_in0 < i_in1};
      ALU_SLL:  o_alu_out = i_in0 << i_in1[4:0];
      ALU_SRL:  o_alu_out = i_in0 >> i_in1[4:0];
      ALU_SRA:  o_alu_out = $unsigned($signed(i_in0) >>> i_in1[4:0]);
      default:  o_err_ufun_unk = 1'b1;
    endcase
  end
endmodule

module alu_rr_arbiter
  import pkg_cpu_types::*;
#(
  parameter int N_REQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0][31:0]  req_in0,
  input  logic [N_REQ-1:0][31:0]  req_in1,
  input  alu_fun_t [N_REQ-1:0]    req_fun,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic [31:0]             busy_cnt
);
  localparam int ID_W = $clog2(N_REQ);

  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     busy_cnt_q, busy_cnt_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

  logic            w_can_accept;
  logic            w_grant_vld;
  logic [ID_W-1:0] w_grant_id;
  logic [31:0]     w_alu_out;
  logic            w_alu_err;

  // Modular increment that also works for non-power-of-two N_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    w_can_accept = !rsp_valid_q || rsp_ready;
    w_grant_vld  = 1'b0;
    w_grant_id   = '0;
    if (!rst && w_can_accept) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!w_grant_vld && req_valid[wrap_add(rr_ptr_q, k)]) begin
          w_grant_vld = 1'b1;
          w_grant_id  = wrap_add(rr_ptr_q, k);
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_grant_vld) req_ready[w_grant_id] = 1'b1;
  end

  alu u_alu (
    .i_in0          (req_in0[w_grant_id]),
    .i_in1          (req_in1[w_grant_id]),
    .i_fun          (req_fun[w_grant_id]),
    .o_alu_out      (w_alu_out),
    .o_err_ufun_unk (w_alu_err)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    rr_ptr_d    = rr_ptr_q;
    busy_cnt_d  = busy_cnt_q + {31'd0, rsp_valid_q};
    if (w_grant_vld) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = w_grant_id;
      rsp_data_d  = w_alu_out;
      rsp_err_d   = w_alu_err;
      rr_ptr_d    = wrap_add(w_grant_id, 1);
    end else if (rsp_valid_q && rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      busy_cnt_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_cnt_q  <= busy_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy_cnt  = busy_cnt_q;

endmodule

`default_nettype wire
